// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding, a ceiling-log2 helper
// and the bit-period divider math. Imported by both the transmit and receive paths
// so that both ends derive the same clocks-per-bit from the same parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Smallest r such that 2**r >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Clocks per serial bit; callers must keep the result >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

  // Width of a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle of the buffered UART transmitter.
//   we, data_tx          : write strobe and byte to enqueue (host -> transmitter)
//   full, empty, count   : FIFO status (transmitter -> host)
//   overflow             : sticky dropped-write flag
//   busy                 : frame in flight or FIFO non-empty
//   txd                  : serial line, idle high
// master = host side, slave = transmitter side.
interface uart_tx_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) ();

  logic             we;
  logic [WIDTH-1:0] data_tx;
  logic             full;
  logic             empty;
  logic [DEPTH:0]   count;
  logic             overflow;
  logic             busy;
  logic             txd;

  modport master (
    output we, data_tx,
    input  full, empty, count, overflow, busy, txd
  );

  modport slave (
    input  we, data_tx,
    output full, empty, count, overflow, busy, txd
  );

endinterface

// File: rtl/fifo_sync.sv
// Synchronous FIFO with 2**DEPTH entries and a registered, first-word-available
// read port: dout always holds the head entry whenever empty is low.
//   clk, reset : clock, asynchronous active-high reset
//   we, din    : push request and data (ignored while full)
//   re         : pop request (ignored while empty)
//   dout       : head entry
//   full/empty : registered occupancy flags
//   count      : registered occupancy, 0..2**DEPTH
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [DEPTH:0]   count
);

  localparam int unsigned Entries = 1 << DEPTH;
  localparam logic [DEPTH:0] PtrOne    = (DEPTH + 1)'(1);
  localparam logic [DEPTH:0] FullCount = (DEPTH + 1)'(Entries);

  logic [WIDTH-1:0] mem_q [Entries];
  logic [DEPTH:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full_q, empty_q;
  logic             push, pop;

  // Flags are last cycle's registered values, so a push while full is dropped even
  // if a pop happens in the same cycle.
  assign push = we && !full_q;
  assign pop  = re && !empty_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = wr_ptr_d - rd_ptr_d;
    // When the next head is the slot being written this cycle, memory does not hold
    // it yet, so forward din.
    if (push && (rd_ptr_d[DEPTH-1:0] == wr_ptr_q[DEPTH-1:0])) begin
      dout_d = din;
    end else begin
      dout_d = mem_q[rd_ptr_d[DEPTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= (count_d == FullCount);
      empty_q  <= (count_d == '0);
    end
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes pushed through the bus interface are queued
// in fifo_sync and serialized LSB-first, one bit per CLK_HZ/SCLK_HZ clocks.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : uart_tx_fifo_if.slave (we, data_tx in; full, empty, count,
//                overflow, busy, txd out). All outputs are registered.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SCLK_HZ = 5000000,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned Div  = calc_div(CLK_HZ, SCLK_HZ);
  localparam int unsigned CntW = cnt_width(Div);
  localparam int unsigned IdxW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DEPTH:0]   fifo_count;
  logic             fifo_re;
  logic             push_ok;

  tx_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] shift_q;
  logic             txd_q;
  logic             busy_q;
  logic             overflow_q;

  assign fifo_re = (state_q == StIdle) && !fifo_empty;
  assign push_ok = bus.we && !fifo_full;

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .we    (bus.we),
    .din   (bus.data_tx),
    .re    (fifo_re),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // busy is set from the next-state view: it follows whether the FSM leaves IDLE
  // and whether the FIFO will hold anything after this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.we && fifo_full) overflow_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          idx_q <= '0;
          txd_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            state_q <= StStart;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= push_ok;
          end
        end
        StStart: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StData;
            txd_q   <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (idx_q == IdxLast) begin
              state_q <= StStop;
              txd_q   <= 1'b1;
            end else begin
              idx_q   <= idx_q + IdxOne;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            busy_q  <= !fifo_empty || push_ok;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.txd      = txd_q;

endmodule
